// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Runs on the system clock and advances only on pix_en ticks. Pixel coordinates come straight
// from the counters; de/hsync/vsync are delayed PIPE_DELAY ticks to line up with framebuffer
// read data.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0,
  parameter int unsigned PIPE_DELAY = 2,
  parameter int unsigned CW         = 12,
  parameter int unsigned FCW        = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_en,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           de,
  output logic           hsync,
  output logic           vsync,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] HLast    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HActive  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActive  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HsStart  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HsEnd    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VsStart  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VsEnd    = CW'(V_ACTIVE + V_FP + V_SYNC);

  // {de, hsync, vsync} as held by every delay stage while in reset
  localparam logic [2:0] SyncIdle = {1'b0, ~HSYNC_POL, ~VSYNC_POL};

  // Reject illegal timing sets at elaboration
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : gen_bad_timing
    $error("vga_timing_gen: every timing value must be at least 1");
  end
  if (CW >= 32 || H_TOTAL >= (32'd1 << CW) || V_TOTAL >= (32'd1 << CW)) begin : gen_bad_cw
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end
  if (PIPE_DELAY > 8) begin : gen_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be 0..8");
  end

  logic [CW-1:0]  h_q, h_d;
  logic [CW-1:0]  v_q, v_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic [2:0]     sync_raw;

  // Raster counter next state: h wraps into v, v wraps into the frame counter
  always_comb begin
    h_d  = h_q;
    v_d  = v_q;
    fc_d = fc_q;
    if (pix_en) begin
      if (h_q == HLast) begin
        h_d = '0;
        if (v_q == VLast) begin
          v_d  = '0;
          fc_d = fc_q + 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Raster counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q  <= '0;
      v_q  <= '0;
      fc_q <= '0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      fc_q <= fc_d;
    end
  end

  // Undelayed decode of the current counters; vsync is a whole-line decode
  always_comb begin
    sync_raw    = SyncIdle;
    sync_raw[2] = (h_q < HActive) && (v_q < VActive);
    sync_raw[1] = ((h_q >= HsStart) && (h_q < HsEnd)) ? HSYNC_POL : ~HSYNC_POL;
    sync_raw[0] = ((v_q >= VsStart) && (v_q < VsEnd)) ? VSYNC_POL : ~VSYNC_POL;
  end

  if (PIPE_DELAY == 0) begin : gen_no_pipe
    assign {de, hsync, vsync} = sync_raw;
  end else begin : gen_pipe
    logic [2:0] pipe_q [PIPE_DELAY];
    logic [2:0] pipe_d [PIPE_DELAY];

    // Shift the decode along one stage per pixel tick, hold otherwise
    always_comb begin
      pipe_d = pipe_q;
      if (pix_en) begin
        pipe_d[0] = sync_raw;
        for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end
    end

    // Delay stages come out of reset showing inactive sync levels
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
          pipe_q[i] <= SyncIdle;
        end
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign {de, hsync, vsync} = pipe_q[PIPE_DELAY-1];
  end

  assign x           = h_q;
  assign y           = v_q;
  assign frame_cnt   = fc_q;
  assign line_start  = pix_en && (h_q == '0);
  assign frame_start = pix_en && (h_q == '0) && (v_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: four parameter sets share one stimulus stream; the
// expected outputs come from the pixel-tick count since reset using plain raster arithmetic.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] fc;
    logic        de;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } out_t;

  typedef struct {
    int unsigned ha, hf, hs, hb, va, vf, vs, vb;
    bit          hp, vp;
    int unsigned pd, fcw;
  } cfg_t;

  typedef struct {
    int   dut;
    out_t e;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  // DUT A: defaults
  logic [11:0] a_x, a_y;
  logic [7:0]  a_fc;
  logic        a_de, a_hs, a_vs, a_ls, a_fs;
  vga_timing_gen u_a (
    .clk(clk), .rst(rst), .pix_en(pix_en), .x(a_x), .y(a_y), .de(a_de), .hsync(a_hs),
    .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
  );

  // DUT B: default timing, positive syncs, no delay
  logic [11:0] b_x, b_y;
  logic [7:0]  b_fc;
  logic        b_de, b_hs, b_vs, b_ls, b_fs;
  vga_timing_gen #(.HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DELAY(0)) u_b (
    .clk(clk), .rst(rst), .pix_en(pix_en), .x(b_x), .y(b_y), .de(b_de), .hsync(b_hs),
    .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
  );

  // DUT C: tiny raster 8x6, one stage of delay
  logic [3:0] c_x, c_y;
  logic [7:0] c_fc;
  logic       c_de, c_hs, c_vs, c_ls, c_fs;
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIPE_DELAY(1), .CW(4), .FCW(8)
  ) u_c (
    .clk(clk), .rst(rst), .pix_en(pix_en), .x(c_x), .y(c_y), .de(c_de), .hsync(c_hs),
    .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs), .frame_cnt(c_fc)
  );

  // DUT D: 28x10 raster, maximum delay, 3-bit frame counter
  logic [7:0] d_x, d_y;
  logic [2:0] d_fc;
  logic       d_de, d_hs, d_vs, d_ls, d_fs;
  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIPE_DELAY(8), .CW(8), .FCW(3)
  ) u_d (
    .clk(clk), .rst(rst), .pix_en(pix_en), .x(d_x), .y(d_y), .de(d_de), .hsync(d_hs),
    .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
  );

  out_t obs [4];
  always_comb begin
    obs[0] = '{x: 16'(a_x), y: 16'(a_y), fc: 16'(a_fc), de: a_de, hs: a_hs, vs: a_vs,
               ls: a_ls, fs: a_fs};
    obs[1] = '{x: 16'(b_x), y: 16'(b_y), fc: 16'(b_fc), de: b_de, hs: b_hs, vs: b_vs,
               ls: b_ls, fs: b_fs};
    obs[2] = '{x: 16'(c_x), y: 16'(c_y), fc: 16'(c_fc), de: c_de, hs: c_hs, vs: c_vs,
               ls: c_ls, fs: c_fs};
    obs[3] = '{x: 16'(d_x), y: 16'(d_y), fc: 16'(d_fc), de: d_de, hs: d_hs, vs: d_vs,
               ls: d_ls, fs: d_fs};
  end

  function automatic cfg_t get_cfg(input int i);
    cfg_t c;
    c = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33,
          hp: 1'b0, vp: 1'b0, pd: 2, fcw: 8};
    case (i)
      1: begin c.hp = 1'b1; c.vp = 1'b1; c.pd = 0; end
      2: c = '{ha: 4, hf: 1, hs: 2, hb: 1, va: 3, vf: 1, vs: 1, vb: 1,
               hp: 1'b0, vp: 1'b0, pd: 1, fcw: 8};
      3: c = '{ha: 20, hf: 2, hs: 3, hb: 3, va: 6, vf: 1, vs: 2, vb: 1,
               hp: 1'b0, vp: 1'b0, pd: 8, fcw: 3};
      default: ;
    endcase
    return c;
  endfunction

  // Expected outputs after t pixel ticks since reset, with pix_en = pe in the current cycle
  function automatic out_t exp_out(input cfg_t c, input longint t, input bit pe);
    out_t   o;
    longint ht, vt, hh, vv, tt;
    ht = longint'(c.ha + c.hf + c.hs + c.hb);
    vt = longint'(c.va + c.vf + c.vs + c.vb);
    o.x  = 16'(t % ht);
    o.y  = 16'((t / ht) % vt);
    o.fc = 16'((t / (ht * vt)) % (64'd1 << c.fcw));
    o.ls = pe && (o.x == 0);
    o.fs = pe && (o.x == 0) && (o.y == 0);
    if (t < longint'(c.pd)) begin
      o.de = 1'b0;
      o.hs = ~c.hp;
      o.vs = ~c.vp;
    end else begin
      tt = t - longint'(c.pd);
      hh = tt % ht;
      vv = (tt / ht) % vt;
      o.de = (hh < c.ha) && (vv < c.va);
      o.hs = (hh >= c.ha + c.hf && hh < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
      o.vs = (vv >= c.va + c.vf && vv < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
    end
    return o;
  endfunction

  sb_item_t sb_q [$];
  int       n_cmp = 0;
  int       n_err = 0;
  longint   ticks = 0;

  // One clock of stimulus: apply inputs, queue the expected view of this cycle, then advance
  task automatic step(input bit r, input bit pe);
    sb_item_t it;
    rst    = r;
    pix_en = pe;
    for (int i = 0; i < 4; i++) begin
      it.dut = i;
      it.e   = exp_out(get_cfg(i), ticks, pe);
      sb_q.push_back(it);
    end
    @(posedge clk);
    if (r) ticks = 0;
    else if (pe) ticks++;
    #1;
  endtask

  // Monitor: every cycle each DUT presents its outputs; compare against queued expectations
  initial begin
    sb_item_t it;
    out_t     got;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        got = obs[it.dut];
        n_cmp++;
        if (got !== it.e) begin
          n_err++;
          $display("FAIL dut%0d @%0t got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d | exp x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                   it.dut, $time, got.x, got.y, got.de, got.hs, got.vs, got.ls, got.fs, got.fc,
                   it.e.x, it.e.y, it.e.de, it.e.hs, it.e.vs, it.e.ls, it.e.fs, it.e.fc);
        end
      end
    end
  end

  initial begin
    int k;
    bit hit;
    // Bring every counter out of X before queueing expectations
    @(posedge clk); #1;
    @(posedge clk); #1;
    ticks = 0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)));
    // Full-rate operation across a few lines of the default raster
    for (int i = 0; i < 2000; i++) step(1'b0, 1'b1);
    // One tick every fourth clock
    for (int i = 0; i < 4000; i++) step(1'b0, (i % 4) == 0);

    // Run to x=700 of the default raster (inside hsync), then reset with pix_en also high
    hit = 1'b0;
    k   = 0;
    while (!hit && k < 2000) begin
      if (ticks % 800 == 700) hit = 1'b1;
      else step(1'b0, 1'b1);
      k++;
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL reach_x700 got no x=700 within %0d ticks required x=700", k);
    end
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);

    // Random pixel strobes with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 499) == 0, 1'($urandom_range(0, 1)));
    end

    // Long full-rate run: small rasters wrap their frame counters
    for (int i = 0; i < 13000; i++) step(1'b0, 1'b1);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_drain got %0d pending required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Successor to the fixed 640x480 counter pair and sync decode.
- Driven by a single system clock with a pixel-enable strobe instead of a derived clock.
- Emits pixel coordinates for framebuffer addressing.
- Emits hsync/vsync/de delayed to match framebuffer read latency, plus frame/line strobes and a frame counter for animation logic (cube rotation stepping).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync level during sync window (0 = active low)
VSYNC_POL, 0, vsync level during sync window
PIPE_DELAY, 2, pix_en ticks of delay on hsync/vsync/de (0..8)
CW, 12, coordinate counter width
FCW, 8, frame counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pix_en  in  1  pixel tick; all timing advances only when high
x  out  CW  current horizontal count, 0..H_TOTAL-1
y  out  CW  current vertical count, 0..V_TOTAL-1
de  out  1  display enable, delayed PIPE_DELAY ticks
hsync  out  1  horizontal sync, delayed PIPE_DELAY ticks
vsync  out  1  vertical sync, delayed PIPE_DELAY ticks
line_start  out  1  one-clk pulse at start of each line (undelayed)
frame_start  out  1  one-clk pulse at start of each frame (undelayed)
frame_cnt  out  FCW  completed-frame count, wraps

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL likewise. Defaults give 800 and 525.
- Line order: active, front porch, sync, back porch. Counter 0 is the first visible pixel.
- Counters are registered and change only on clk edges with pix_en=1:
  - h == H_TOTAL-1: h <- 0 and v advances.
  - v == V_TOTAL-1 at that point: v <- 0.
  - Otherwise h <- h+1.
- x = h and y = v, undelayed and registered.
- Raw decode (combinational from counters):
  - de_raw = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hs_raw = HSYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL.
  - vs_raw = VSYNC_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~VSYNC_POL.
  - vs_raw is a whole-line decode, aligned to h=0.
- Delay line:
  - PIPE_DELAY-stage shift register for {de, hsync, vsync}. Shifts only when pix_en=1 and holds otherwise.
  - Stage 0 loads the raw decode of the current counters.
  - PIPE_DELAY=0 means outputs equal the raw decode directly.
- line_start = pix_en && h==0. frame_start = pix_en && h==0 && v==0. Both are combinational, one clk wide, never asserted when pix_en=0.
- frame_cnt increments by 1 on pix_en && h==H_TOTAL-1 && v==V_TOTAL-1, and wraps from 2^FCW-1 to 0.
- Reset (synchronous, any time including mid-line or mid-sync):
  - h, v, frame_cnt <- 0.
  - Every delay stage <- de=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - Outputs therefore show inactive levels for PIPE_DELAY ticks after reset, then track the counters.
- rst takes priority over pix_en in the same cycle; no counter advance occurs.
- First pix_en after reset release yields frame_start=1 and line_start=1 in that cycle.
- pix_en held high continuously is legal (full-rate operation).
- Parameter legality, checked by elaboration assertion:
  - All timing values >= 1.
  - H_TOTAL and V_TOTAL < 2^CW.
  - PIPE_DELAY <= 8.

Test Plan:
- Reset, then pix_en=1 constant, defaults -> x counts 0..799 then 0, y increments at wrap; de=1 for exactly 640 ticks per visible line starting 2 ticks after x=0; hsync=0 for 96 ticks starting 2 ticks after x=656.
- Full frame at pix_en=1 -> frame_start pulses exactly 420000 clks apart; vsync=0 across lines 490-491 only; frame_cnt 0->1 at first wrap; force 255 -> wraps to 0.
- pix_en high every 4th clk -> x, y, de, hsync and vsync unchanged on the 3 idle clks; line period = 3200 clks; line_start never high on idle clks.
- Assert rst mid-sync (x=700, y=491) -> next cycle x=0, y=0, hsync=vsync=1, de=0; held through 2 pix_en ticks, then de=1.
- HSYNC_POL=1, VSYNC_POL=1, PIPE_DELAY=0 -> hsync=1 exactly while x in [656,752) in the same cycle; vsync=1 while y in [490,492).
- Small parameter set (H: 4/1/2/1, V: 3/1/1/1, PIPE_DELAY=1) -> H_TOTAL=8, V_TOTAL=6; exhaustive compare against reference model over 3 frames.
